// File: rtl/csr_mgr_pkg.sv
// Shared types and constants for the application CSR manager.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csr_mgr_pkg;

  localparam int NUM_CSR_MGR_COUNTER_BITS = 40;
  typedef logic [NUM_CSR_MGR_COUNTER_BITS-1:0] t_csr_mgr_counter;

  typedef logic [8:0] t_mmio_tid;

  typedef struct packed {
    t_mmio_tid   tid;
    logic [63:0] dat;
  } mmio_rsp_t;

  // DFH: feature type AFU in [63:60], end-of-list in [40]
  localparam logic [63:0] CSR_MGR_DFH = 64'h1000_0100_0000_0000;

  // Fixed byte offsets of the manager-owned registers
  localparam logic [15:0] OFS_DFH       = 16'h0000;
  localparam logic [15:0] OFS_AFU_ID_L  = 16'h0008;
  localparam logic [15:0] OFS_AFU_ID_H  = 16'h0010;
  localparam logic [15:0] OFS_RSVD      = 16'h0018;
  localparam logic [15:0] OFS_CYCLE_CNT = 16'h0028;

endpackage

// File: rtl/csr_mgr_rsp_pipe.sv
// Two-stage MMIO read response pipeline (valid, tid, data).
// Latency: 2 cycles from accepted read to response.
// Backpressure: none; one response per cycle, reset discards in-flight reads.
module csr_mgr_rsp_pipe
  import csr_mgr_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      rd_vld,
  input  mmio_rsp_t rd_dat,
  output logic      rsp_vld,
  output mmio_rsp_t rsp_dat
);

  logic      s1_vld;
  mmio_rsp_t s1_dat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_dat  <= '0;
      rsp_vld <= 1'b0;
      rsp_dat <= '0;
    end else begin
      s1_vld  <= rd_vld;
      s1_dat  <= rd_dat;
      rsp_vld <= s1_vld;
      rsp_dat <= s1_dat;
    end
  end

endmodule

// File: rtl/app_csr_mgr.sv
// CCI-P MMIO CSR manager: DFH, AFU ID, cycle counter and N_CSRS application CSRs.
// Latency: writes/read strobes at T+1, read responses at T+2.
// Backpressure: none; one request per cycle, a read colliding with a write is dropped.
module app_csr_mgr
  import csr_mgr_pkg::*;
#(
  parameter int N_CSRS   = 8,
  parameter int CSR_BASE = 'h40
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mmio_rd_valid,
  input  logic                   mmio_wr_valid,
  input  logic [15:0]            mmio_addr,
  input  logic                   mmio_len,
  input  logic [8:0]             mmio_tid,
  input  logic [63:0]            mmio_wr_data,
  input  logic [127:0]           afu_id,
  input  logic [64*N_CSRS-1:0]   app_rd_data,
  output logic                   mmio_rsp_valid,
  output logic [8:0]             mmio_rsp_tid,
  output logic [63:0]            mmio_rsp_data,
  output logic [N_CSRS-1:0]      app_wr_en,
  output logic [63:0]            app_wr_data,
  output logic [N_CSRS-1:0]      app_rd_strobe,
  output logic                   err_rd_dropped
);

  localparam logic [15:0] BASE_QW = 16'(CSR_BASE / 8);

  logic [14:0]       qw;
  logic [15:0]       rel;
  logic              misaligned;
  logic              csr_hit;
  logic              wr_ok;
  logic              rd_ok;
  logic              cnt_clr;
  logic [N_CSRS-1:0] csr_sel;
  logic [63:0]       shadow_q [N_CSRS];
  logic [63:0]       cur_shadow;
  logic [63:0]       new_shadow;
  logic [63:0]       app_qw;
  logic [63:0]       rd_qw;
  logic [63:0]       rd_dat;
  t_csr_mgr_counter  cnt_q;
  mmio_rsp_t         rd_rsp;
  mmio_rsp_t         rsp;

  // Decode on the qword address; mmio_addr[0] only picks the DWORD half
  assign qw         = mmio_addr[15:1];
  assign rel        = {1'b0, qw} - BASE_QW;
  assign csr_hit    = ({1'b0, qw} >= BASE_QW) && (rel < 16'(N_CSRS));
  assign misaligned = mmio_len & mmio_addr[0];
  assign wr_ok      = mmio_wr_valid & ~misaligned;
  assign rd_ok      = mmio_rd_valid & ~mmio_wr_valid;
  assign cnt_clr    = wr_ok && (qw == 15'(OFS_CYCLE_CNT >> 3));

  always_comb begin
    csr_sel = '0;
    for (int i = 0; i < N_CSRS; i++) begin
      csr_sel[i] = csr_hit && (rel == 16'(i));
    end
  end

  always_comb begin
    cur_shadow = '0;
    app_qw     = '0;
    for (int i = 0; i < N_CSRS; i++) begin
      if (csr_sel[i]) begin
        cur_shadow = shadow_q[i];
        app_qw     = app_rd_data[64*i +: 64];
      end
    end
  end

  always_comb begin
    if (mmio_len) begin
      new_shadow = mmio_wr_data;
    end else if (mmio_addr[0]) begin
      new_shadow = {mmio_wr_data[31:0], cur_shadow[31:0]};
    end else begin
      new_shadow = {cur_shadow[63:32], mmio_wr_data[31:0]};
    end
  end

  always_comb begin
    rd_qw = '0;
    if (qw == 15'(OFS_DFH >> 3)) begin
      rd_qw = CSR_MGR_DFH;
    end else if (qw == 15'(OFS_AFU_ID_L >> 3)) begin
      rd_qw = afu_id[63:0];
    end else if (qw == 15'(OFS_AFU_ID_H >> 3)) begin
      rd_qw = afu_id[127:64];
    end else if (qw == 15'(OFS_CYCLE_CNT >> 3)) begin
      rd_qw = {{(64-NUM_CSR_MGR_COUNTER_BITS){1'b0}}, cnt_q};
    end else if (csr_hit) begin
      rd_qw = app_qw;
    end

    if (misaligned) begin
      rd_dat = '0;
    end else if (mmio_len) begin
      rd_dat = rd_qw;
    end else if (mmio_addr[0]) begin
      rd_dat = {32'b0, rd_qw[63:32]};
    end else begin
      rd_dat = {32'b0, rd_qw[31:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CSRS; i++) begin
        shadow_q[i] <= '0;
      end
      cnt_q          <= '0;
      app_wr_en      <= '0;
      app_wr_data    <= '0;
      app_rd_strobe  <= '0;
      err_rd_dropped <= 1'b0;
    end else begin
      for (int i = 0; i < N_CSRS; i++) begin
        if (wr_ok && csr_sel[i]) begin
          shadow_q[i] <= new_shadow;
        end
      end
      cnt_q         <= cnt_clr ? '0 : cnt_q + 1'b1;
      app_wr_en     <= wr_ok ? csr_sel : '0;
      if (wr_ok && csr_hit) begin
        app_wr_data <= new_shadow;
      end
      // Misaligned reads return 0 without touching the application CSR
      app_rd_strobe  <= (rd_ok && !misaligned) ? csr_sel : '0;
      err_rd_dropped <= err_rd_dropped | (mmio_rd_valid & mmio_wr_valid);
    end
  end

  assign rd_rsp = '{tid: mmio_tid, dat: rd_dat};

  csr_mgr_rsp_pipe u_rsp_pipe (
    .clk     (clk),
    .reset   (reset),
    .rd_vld  (rd_ok),
    .rd_dat  (rd_rsp),
    .rsp_vld (mmio_rsp_valid),
    .rsp_dat (rsp)
  );

  assign mmio_rsp_tid  = rsp.tid;
  assign mmio_rsp_data = rsp.dat;

endmodule

// File: tb/tb_app_csr_mgr.sv
// Bench for app_csr_mgr: directed literal cases plus randomized traffic against a cycle-indexed model.
// Outputs are compared every cycle at 1 time unit after the rising edge.
module tb_app_csr_mgr;

  localparam int N    = 8;
  localparam int BASE = 'h40;
  localparam logic [127:0] AFU_ID = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam int NEVER = 32'h7fff_ffff;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             mmio_rd_valid = 1'b0;
  logic             mmio_wr_valid = 1'b0;
  logic [15:0]      mmio_addr = '0;
  logic             mmio_len = 1'b0;
  logic [8:0]       mmio_tid = '0;
  logic [63:0]      mmio_wr_data = '0;
  logic [127:0]     afu_id = AFU_ID;
  logic [64*N-1:0]  app_rd_data = '0;
  logic             mmio_rsp_valid;
  logic [8:0]       mmio_rsp_tid;
  logic [63:0]      mmio_rsp_data;
  logic [N-1:0]     app_wr_en;
  logic [63:0]      app_wr_data;
  logic [N-1:0]     app_rd_strobe;
  logic             err_rd_dropped;

  app_csr_mgr #(.N_CSRS(N), .CSR_BASE(BASE)) dut (
    .clk            (clk),
    .reset          (reset),
    .mmio_rd_valid  (mmio_rd_valid),
    .mmio_wr_valid  (mmio_wr_valid),
    .mmio_addr      (mmio_addr),
    .mmio_len       (mmio_len),
    .mmio_tid       (mmio_tid),
    .mmio_wr_data   (mmio_wr_data),
    .afu_id         (afu_id),
    .app_rd_data    (app_rd_data),
    .mmio_rsp_valid (mmio_rsp_valid),
    .mmio_rsp_tid   (mmio_rsp_tid),
    .mmio_rsp_data  (mmio_rsp_data),
    .app_wr_en      (app_wr_en),
    .app_wr_data    (app_wr_data),
    .app_rd_strobe  (app_rd_strobe),
    .err_rd_dropped (err_rd_dropped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rand_app = 1'b0;

  // Model: expected outputs keyed by the cycle in which they must be visible
  logic [63:0]  e_rsp_dat [int];
  logic [8:0]   e_rsp_tid [int];
  logic [N-1:0] e_strb    [int];
  logic [N-1:0] e_wren    [int];
  logic [63:0]  e_wdat    [int];
  logic [63:0]  l_rsp     [int];
  logic [N-1:0] l_strb    [int];
  logic [N-1:0] l_wren    [int];
  logic [63:0]  l_wdat    [int];
  logic [63:0]  sh_m [N];
  longint       cnt_base = 0;
  int           err_cyc = NEVER;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp, input int c);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, c, act, exp);
    end
  endtask

  function automatic logic [39:0] cnt_at(input int t);
    return 40'(longint'(t) - cnt_base);
  endfunction

  function automatic int csr_of(input int qbyte);
    if (qbyte >= BASE && (qbyte - BASE) / 8 < N) return (qbyte - BASE) / 8;
    return -1;
  endfunction

  function automatic logic [63:0] mdl_rd(input int t);
    int qb = int'(mmio_addr[15:1]) * 8;
    int ci = csr_of(qb);
    logic [63:0] q = '0;
    if (mmio_len && mmio_addr[0]) return 64'h0;
    if (qb == 'h00)      q = 64'h1000_0100_0000_0000;
    else if (qb == 'h08) q = afu_id[63:0];
    else if (qb == 'h10) q = afu_id[127:64];
    else if (qb == 'h28) q = {24'h0, cnt_at(t)};
    else if (ci >= 0)    q = app_rd_data[64*ci +: 64];
    if (mmio_len) return q;
    return mmio_addr[0] ? (q >> 32) : (q & 64'hFFFF_FFFF);
  endfunction

  task automatic model_req(input int t);
    int qb = int'(mmio_addr[15:1]) * 8;
    int ci = csr_of(qb);
    bit mis = mmio_len && mmio_addr[0];
    logic [N-1:0] one = {{(N-1){1'b0}}, 1'b1};
    if (mmio_rd_valid && mmio_wr_valid && err_cyc > t + 1) err_cyc = t + 1;
    if (mmio_wr_valid && !mis) begin
      if (qb == 'h28) cnt_base = longint'(t + 1);
      if (ci >= 0) begin
        if (mmio_len)          sh_m[ci] = mmio_wr_data;
        else if (mmio_addr[0]) sh_m[ci][63:32] = mmio_wr_data[31:0];
        else                   sh_m[ci][31:0] = mmio_wr_data[31:0];
        e_wren[t+1] = one << ci;
        e_wdat[t+1] = sh_m[ci];
      end
    end
    if (mmio_rd_valid && !mmio_wr_valid) begin
      e_rsp_dat[t+2] = mdl_rd(t);
      e_rsp_tid[t+2] = mmio_tid;
      if (ci >= 0 && !mis) e_strb[t+1] = one << ci;
    end
  endtask

  task automatic model_reset();
    e_rsp_dat.delete(); e_rsp_tid.delete(); e_strb.delete(); e_wren.delete(); e_wdat.delete();
    l_rsp.delete(); l_strb.delete(); l_wren.delete(); l_wdat.delete();
    for (int i = 0; i < N; i++) sh_m[i] = '0;
    err_cyc = NEVER;
  endtask

  task automatic compare_cycle(input int c);
    bit ev = e_rsp_dat.exists(c);
    logic [N-1:0] es = e_strb.exists(c) ? e_strb[c] : '0;
    logic [N-1:0] ew = e_wren.exists(c) ? e_wren[c] : '0;
    chk("rsp_valid", 64'(mmio_rsp_valid), 64'(ev), c);
    if (ev) begin
      chk("rsp_tid", 64'(mmio_rsp_tid), 64'(e_rsp_tid[c]), c);
      chk("rsp_data", mmio_rsp_data, e_rsp_dat[c], c);
    end
    chk("rd_strobe", 64'(app_rd_strobe), 64'(es), c);
    chk("wr_en", 64'(app_wr_en), 64'(ew), c);
    if (e_wdat.exists(c)) chk("wr_data", app_wr_data, e_wdat[c], c);
    chk("err_rd_dropped", 64'(err_rd_dropped), 64'(c >= err_cyc), c);
    if (l_rsp.exists(c)) begin
      chk("lit_rsp_data", mmio_rsp_data, l_rsp[c], c);
      chk("model_rsp_vs_lit", ev ? e_rsp_dat[c] : 64'hBAD0_BAD0_BAD0_BAD0, l_rsp[c], c);
    end
    if (l_strb.exists(c)) chk("lit_rd_strobe", 64'(app_rd_strobe), 64'(l_strb[c]), c);
    if (l_wren.exists(c)) begin
      chk("lit_wr_en", 64'(app_wr_en), 64'(l_wren[c]), c);
      chk("model_wren_vs_lit", 64'(ew), 64'(l_wren[c]), c);
    end
    if (l_wdat.exists(c)) chk("lit_wr_data", app_wr_data, l_wdat[c], c);
    if (reset) begin
      chk("reset_wr_data", app_wr_data, 64'h0, c);
      chk("reset_rsp_data", mmio_rsp_data, 64'h0, c);
      chk("reset_rsp_tid", 64'(mmio_rsp_tid), 64'h0, c);
    end
    e_rsp_dat.delete(c); e_rsp_tid.delete(c); e_strb.delete(c); e_wren.delete(c); e_wdat.delete(c);
    l_rsp.delete(c); l_strb.delete(c); l_wren.delete(c); l_wdat.delete(c);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      compare_cycle(cyc);
    end
  end

  task automatic drv(input bit rd, input bit wr, input logic [15:0] a, input bit len,
                     input logic [8:0] tid, input logic [63:0] d);
    @(negedge clk);
    if (rand_app) begin
      for (int i = 0; i < 2 * N; i++) app_rd_data[32*i +: 32] = $urandom;
    end
    mmio_rd_valid = rd;
    mmio_wr_valid = wr;
    mmio_addr     = a;
    mmio_len      = len;
    mmio_tid      = tid;
    mmio_wr_data  = d;
    model_req(cyc);
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 16'h0, 1'b0, 9'h0, 64'h0);
  endtask

  task automatic rd_lit(input int byte_ofs, input bit half, input bit len, input logic [8:0] tid,
                        input logic [63:0] lit);
    drv(1'b1, 1'b0, 16'(byte_ofs >> 2) | 16'(half), len, tid, 64'h0);
    l_rsp[cyc+2] = lit;
  endtask

  task automatic rand_phase(input int n);
    rand_app = 1'b1;
    for (int k = 0; k < n; k++) begin
      int r = $urandom_range(0, 15);
      int sel = $urandom_range(0, 8 + N);
      int b = (sel < 8) ? sel * 8 : BASE + 8 * (sel - 8);
      logic [15:0] a = 16'(b >> 2) | 16'($urandom_range(0, 1));
      logic [63:0] d = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) a = 16'($urandom);
      drv(r <= 6 || r == 13, (r >= 7 && r <= 13), a, 1'($urandom_range(0, 1)),
          9'($urandom_range(0, 511)), d);
    end
    rand_app = 1'b0;
    idle();
  endtask

  task automatic do_reset(input int n);
    mmio_rd_valid = 1'b0;
    mmio_wr_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (n) @(negedge clk);
    reset = 1'b0;
    cnt_base = longint'(cyc);
  endtask

  initial begin
    int t0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cnt_base = longint'(cyc);

    // ID registers back to back
    rd_lit('h00, 1'b0, 1'b1, 9'd1, 64'h1000_0100_0000_0000);
    rd_lit('h08, 1'b0, 1'b1, 9'd2, 64'hFEDC_BA98_7654_3210);
    rd_lit('h10, 1'b0, 1'b1, 9'd3, 64'h0123_4567_89AB_CDEF);
    idle();

    // Shadow merge on CSR 1
    drv(1'b0, 1'b1, 16'(('h40 + 8) >> 2), 1'b1, 9'd0, 64'hDEAD_BEEF_0123_4567);
    l_wren[cyc+1] = 8'b0000_0010;
    l_wdat[cyc+1] = 64'hDEAD_BEEF_0123_4567;
    drv(1'b0, 1'b1, 16'(('h40 + 8) >> 2) + 16'd1, 1'b0, 9'd0, 64'hFFFF_FFFF_AAAA_5555);
    l_wren[cyc+1] = 8'b0000_0010;
    l_wdat[cyc+1] = 64'hAAAA_5555_0123_4567;
    idle();

    // Upper-half read of CSR 2
    app_rd_data[2*64 +: 64] = 64'h1111_2222_3333_4444;
    rd_lit('h50, 1'b1, 1'b0, 9'd7, 64'h0000_0000_1111_2222);
    l_strb[cyc+1] = 8'b0000_0100;
    l_strb[cyc+2] = 8'b0000_0000;
    idle();

    // Counter clear then read-back
    drv(1'b0, 1'b1, 16'('h28 >> 2), 1'b1, 9'd0, 64'h1234);
    t0 = cyc;
    rd_lit('h28, 1'b0, 1'b1, 9'd8, 64'h0);
    while (cyc < t0 + 9) idle();
    rd_lit('h28, 1'b0, 1'b1, 9'd9, 64'd9);
    idle();

    // Unmapped, reserved and misaligned reads; misaligned write ignored
    rd_lit('h30, 1'b0, 1'b1, 9'd10, 64'h0);
    rd_lit('h18, 1'b0, 1'b1, 9'd11, 64'h0);
    rd_lit('h08, 1'b1, 1'b1, 9'd12, 64'h0);
    drv(1'b0, 1'b1, 16'('h48 >> 2) | 16'd1, 1'b1, 9'd0, 64'h5A5A);
    l_wren[cyc+1] = 8'b0;
    idle();

    // Read colliding with write on CSR 3
    drv(1'b1, 1'b1, 16'('h58 >> 2), 1'b1, 9'd13, 64'hCAFE_F00D_0000_0003);
    l_wren[cyc+1] = 8'b0000_1000;
    l_wdat[cyc+1] = 64'hCAFE_F00D_0000_0003;
    repeat (3) idle();

    // Counter wrap from all-ones
    @(negedge clk);
    dut.cnt_q = '1;
    cnt_base = longint'(cyc) - ((longint'(1) << 40) - 1);
    mmio_rd_valid = 1'b1; mmio_wr_valid = 1'b0; mmio_addr = 16'('h28 >> 2);
    mmio_len = 1'b1; mmio_tid = 9'd14;
    model_req(cyc);
    l_rsp[cyc+2] = 64'h0000_00FF_FFFF_FFFF;
    rd_lit('h28, 1'b0, 1'b1, 9'd15, 64'h0);
    idle();

    rand_phase(1500);

    // Reset with reads in flight
    rd_lit('h00, 1'b0, 1'b1, 9'd20, 64'h1000_0100_0000_0000);
    rd_lit('h08, 1'b0, 1'b1, 9'd21, 64'hFEDC_BA98_7654_3210);
    #2;
    do_reset(3);
    repeat (4) idle();

    rand_phase(600);
    repeat (4) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
